// File: rtl/cc_unit.sv
// cc_unit: condition-code register and jXX/cmovXX condition evaluator.
//
// Takes the ALU operands and result, derives the next ZF/SF/OF and latches them
// when set_cc is asserted (and the pipeline is not stalled). The condition
// output cnd is evaluated from the latched flags only.
//
// Ports:
//   clk      - system clock, rising-edge active
//   rst      - synchronous active-high reset (priority over stall/set_cc)
//   alu_a    - ALU operand A (valA or valC), two's complement
//   alu_b    - ALU operand B (valB), two's complement
//   alu_out  - ALU result (trusted, not recomputed)
//   alu_fun  - 0 add (B+A), 1 sub (B-A), 2 and, 3 xor; others invalid
//   set_cc   - request to latch new flags this cycle
//   stall    - hold all state; overrides set_cc
//   cond_fun - 0 always, 1 le, 2 l, 3 e, 4 ne, 5 ge, 6 g; others give 0
//   zf/sf/of - registered flags
//   cnd      - combinational condition result from registered flags
//   fun_err  - sticky: an update was accepted with an invalid alu_fun
//   upd_cnt  - number of accepted flag updates, wraps modulo 256
module cc_unit #(
    parameter int         WIDTH    = 64,
    parameter logic [2:0] CC_RESET = 3'b100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] alu_a,
    input  logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_out,
    input  logic [3:0]       alu_fun,
    input  logic             set_cc,
    input  logic             stall,
    input  logic [3:0]       cond_fun,
    output logic             zf,
    output logic             sf,
    output logic             of,
    output logic             cnd,
    output logic             fun_err,
    output logic [7:0]       upd_cnt
);

    localparam logic [3:0] FUN_ADD = 4'd0;
    localparam logic [3:0] FUN_SUB = 4'd1;

    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic signed [WIDTH-1:0] out_s;

    assign a_s   = $signed(alu_a);
    assign b_s   = $signed(alu_b);
    assign out_s = $signed(alu_out);

    // Overflow from sign bits only: add overflows when like-signed operands
    // produce a result of the other sign; sub (B-A) overflows when the
    // operands differ in sign and the result's sign differs from B.
    function automatic logic ovf_calc(input logic [3:0] fun,
                                      input logic       sa,
                                      input logic       sb,
                                      input logic       so);
        logic r;
        r = 1'b0;
        if (fun == FUN_ADD)
            r = (sa == sb) && (so != sa);
        else if (fun == FUN_SUB)
            r = (sa != sb) && (so != sb);
        return r;
    endfunction

    logic nzf;
    logic nsf;
    logic nof;
    logic fun_ok;
    logic accept;

    assign nzf    = (out_s == '0);
    assign nsf    = out_s < 0;
    assign nof    = ovf_calc(alu_fun, a_s[WIDTH-1], b_s[WIDTH-1], out_s[WIDTH-1]);
    assign fun_ok = (alu_fun <= 4'd3);
    assign accept = set_cc && !stall;

    // Flag register stage
    always_ff @(posedge clk) begin
        if (rst) begin
            {zf, sf, of} <= CC_RESET;
            fun_err      <= 1'b0;
            upd_cnt      <= 8'd0;
        end else if (accept) begin
            if (fun_ok) begin
                {zf, sf, of} <= {nzf, nsf, nof};
                upd_cnt      <= upd_cnt + 8'd1;
            end else begin
                fun_err <= 1'b1;
            end
        end
    end

    // Condition evaluation from latched flags only
    logic x;
    assign x = sf ^ of;

    always_comb begin
        cnd = 1'b0;
        case (cond_fun)
            4'd0:    cnd = 1'b1;
            4'd1:    cnd = x | zf;
            4'd2:    cnd = x;
            4'd3:    cnd = zf;
            4'd4:    cnd = ~zf;
            4'd5:    cnd = ~x;
            4'd6:    cnd = ~x & ~zf;
            default: cnd = 1'b0;
        endcase
    end

endmodule
